// File: rtl/instr_sequencer_if.sv
// Fetch/data memory handshake and datapath strobe bundle for instr_sequencer.
// master = sequencer side, slave = memory/datapath environment side.
interface instr_sequencer_if;
  logic        start;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic [31:0] instr;
  logic        imm_control;
  logic        alu_src_imm;
  logic        rf_we;
  logic        pc_we;
  logic        busy;
  logic        retired;
  logic        illegal;
  logic [31:0] instret;

  modport master (
    input  start, imem_ack, imem_rdata, dmem_ack,
    output imem_req, dmem_req, dmem_we, instr,
    output imm_control, alu_src_imm, rf_we, pc_we,
    output busy, retired, illegal, instret
  );

  modport slave (
    output start, imem_ack, imem_rdata, dmem_ack,
    input  imem_req, dmem_req, dmem_we, instr,
    input  imm_control, alu_src_imm, rf_we, pc_we,
    input  busy, retired, illegal, instret
  );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle RV32 instruction sequencer: fetch, decode, exec, mem, wb, trap.
// Define CUSTOM_ADUQ_EN to accept custom-0 opcode 0001011 as an R-type.
module instr_sequencer (
  input  logic                  clk,
  input  logic                  reset,
  instr_sequencer_if.master     bus
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  localparam logic [2:0] C_R    = 3'd0;
  localparam logic [2:0] C_I    = 3'd1;
  localparam logic [2:0] C_JALR = 3'd2;
  localparam logic [2:0] C_JAL  = 3'd3;
  localparam logic [2:0] C_LW   = 3'd4;
  localparam logic [2:0] C_SW   = 3'd5;
  localparam logic [2:0] C_BEQ  = 3'd6;
  localparam logic [2:0] C_ILL  = 3'd7;

  logic [2:0]  r_state;
  logic [2:0]  r_cls;
  logic [31:0] r_instr;
  logic [31:0] r_instret;
  logic        r_illegal;

  logic [6:0]  w_op;
  logic [2:0]  w_cls;
  logic [2:0]  w_after;
  logic        w_wb;
  logic        w_beq_ret;
  logic        w_sw_ret;
  logic        w_retired;

  assign w_op = r_instr[6:0];

  always_comb begin
    w_cls = C_ILL;
    unique case (1'b1)
      (w_op == 7'b0110011): w_cls = C_R;
      (w_op == 7'b0010011),
      (w_op == 7'b0110111),
      (w_op == 7'b0010111): w_cls = C_I;
      (w_op == 7'b1100111): w_cls = C_JALR;
      (w_op == 7'b1101111): w_cls = C_JAL;
      (w_op == 7'b0000011): w_cls = C_LW;
      (w_op == 7'b0100011): w_cls = C_SW;
      (w_op == 7'b1100011): w_cls = C_BEQ;
`ifdef CUSTOM_ADUQ_EN
      (w_op == 7'b0001011): w_cls = C_R;
`endif
      default:              w_cls = C_ILL;
    endcase
  end

  // start is re-sampled only at retire, so dropping it never aborts
  assign w_after   = bus.start ? S_FETCH : S_IDLE;
  assign w_wb      = (r_state == S_WB);
  assign w_beq_ret = (r_state == S_EXEC) && (r_cls == C_BEQ);
  assign w_sw_ret  = (r_state == S_MEM) && (r_cls == C_SW)
                   && bus.dmem_ack;
  assign w_retired = w_wb || w_beq_ret || w_sw_ret;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cls     <= C_R;
      r_instr   <= 32'd0;
      r_instret <= 32'd0;
      r_illegal <= 1'b0;
    end else begin
      r_instret <= r_instret + {31'd0, w_retired};
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (bus.imem_ack) begin
            r_instr <= bus.imem_rdata;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_cls <= w_cls;
          if (w_cls == C_ILL) begin
            r_illegal <= 1'b1;
            r_state   <= S_TRAP;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_cls == C_BEQ)
            r_state <= w_after;
          else if (r_cls == C_LW || r_cls == C_SW)
            r_state <= S_MEM;
          else
            r_state <= S_WB;
        end
        S_MEM: begin
          if (bus.dmem_ack)
            r_state <= (r_cls == C_SW) ? w_after : S_WB;
        end
        S_WB:    r_state <= w_after;
        S_TRAP:  r_state <= S_TRAP;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = (r_state != S_IDLE) && (r_state != S_TRAP);
  assign bus.imem_req    = (r_state == S_FETCH);
  assign bus.imm_control = (r_state == S_DECODE);
  assign bus.alu_src_imm = (r_state == S_EXEC) && (r_cls != C_R)
                         && (r_cls != C_BEQ);
  assign bus.dmem_req    = (r_state == S_MEM);
  assign bus.dmem_we     = (r_state == S_MEM) && (r_cls == C_SW);
  assign bus.rf_we       = w_wb;
  assign bus.pc_we       = w_retired;
  assign bus.retired     = w_retired;
  assign bus.instr       = r_instr;
  assign bus.illegal     = r_illegal;
  assign bus.instret     = r_instret;
endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: start  in  1  run enable, level-sensitive.
REQ-004 SHALL have ports: imem_req  out  1, imem_ack  in  1, imem_rdata  in  32  instruction fetch handshake and data.
REQ-005 SHALL have ports: dmem_req  out  1, dmem_we  out  1, dmem_ack  in  1  data memory handshake; dmem_we is 1 for SW.
REQ-006 SHALL have ports: instr  out  32  latched instruction register, feeds immediate decoder.
REQ-007 SHALL have ports: imm_control  out  1  immediate decoder enable.
REQ-008 SHALL have ports: alu_src_imm  out  1, rf_we  out  1, pc_we  out  1  datapath strobes.
REQ-009 SHALL have ports: busy  out  1, retired  out  1  one-cycle retire pulse, illegal  out  1  sticky trap flag, instret  out  32  retired-instruction count.

Function
REQ-010 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP; busy=1 in every state except IDLE and TRAP.
REQ-011 IDLE: SHALL move to FETCH when start=1, else hold.
REQ-012 FETCH: SHALL hold imem_req=1 until a cycle with imem_ack=1, latch imem_rdata into instr on that edge, and go to DECODE; imem_ack outside FETCH SHALL be ignored.
REQ-013 DECODE: SHALL assert imm_control=1 for exactly this cycle and classify instr[6:0]: 0110011 R; 0010011/0110111/0010111 I-ALU; 1100111 JALR; 1101111 JAL; 0000011 LW; 0100011 SW; 1100011 BEQ; other opcodes SHALL be illegal.
REQ-014 DECODE on illegal SHALL go to TRAP; otherwise to EXEC.
REQ-015 EXEC: SHALL set alu_src_imm=1 for every class except R and BEQ; BEQ SHALL assert pc_we and retired, then go to FETCH or IDLE per REQ-019; LW/SW SHALL go to MEM; all other classes SHALL go to WB.
REQ-016 MEM: SHALL hold dmem_req=1, dmem_we=(SW), until dmem_ack=1; on ack, LW SHALL go to WB and SW SHALL assert pc_we and retired and leave per REQ-019.
REQ-017 WB: SHALL assert rf_we=1, pc_we=1 and retired=1 for one cycle, then leave per REQ-019.
REQ-018 Minimum latency with same-cycle ack, FETCH to retire inclusive: BEQ 3 cycles, R/I-ALU/JAL/JALR 4, SW 4, LW 5.
REQ-019 On retire SHALL go to FETCH if start=1, else IDLE; start dropping mid-instruction SHALL NOT abort it.
REQ-020 instret SHALL increment by 1 on every retired pulse and wrap from 0xFFFFFFFF to 0.
REQ-021 TRAP: SHALL hold illegal=1 and all strobes at 0 and ignore start until reset.
REQ-022 All strobes not named active in a state SHALL be 0 in that state.

Reset
REQ-023 reset=1 SHALL force IDLE, instr=0, instret=0, illegal=0 and every output to 0 on the next edge, including mid-FETCH or mid-MEM; a pending memory request SHALL be abandoned.
REQ-024 reset SHALL take priority over every other input in the same cycle.

Configuration
REQ-025 With CUSTOM_ADUQ_EN defined, opcode 0001011 SHALL be classified R (4-cycle, rf_we in WB, alu_src_imm=0); without it, 0001011 SHALL be illegal and enter TRAP.

Verification
REQ-026 ADD 0x00000033, ack same cycle, start=1 -> imm_control high exactly in DECODE, rf_we+retired in cycle 4, instret=1.
REQ-027 LW 0x00002003, dmem_ack delayed 3 cycles -> dmem_req high 4 cycles with dmem_we=0, retire in cycle 8, rf_we=1 once.
REQ-028 SW 0x00202023 then BEQ 0x00000063 -> dmem_we=1 in MEM, no rf_we on either instruction, instret=2.
REQ-029 Opcode 0x0000000B -> TRAP with illegal=1 if CUSTOM_ADUQ_EN is undefined; rf_we in cycle 4 and instret=1 if defined.
REQ-030 instret preloaded to 0xFFFFFFFF by forcing, one ADDI 0x00500093 -> instret=0; reset asserted mid-MEM -> IDLE next cycle, dmem_req=0, instret=0.
